io_input_conditioner: RTL and testbench
=======================================

IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive differing synchronized samples needed to accept a new input level (1 ms at 50 MHz).
REQ-002 Parameter CNT_W, default 16, width of each debounce counter.
REQ-003 DEBOUNCE_CYCLES SHALL satisfy 1 <= DEBOUNCE_CYCLES < 2^CNT_W.
REQ-004 clock  input  1  single rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sw_raw  input  18  asynchronous board switches.
REQ-007 btn_raw  input  1  asynchronous board push-button.
REQ-008 in_port0  output  32  {24'b0, debounced sw[7:0]}.
REQ-009 in_port1  output  32  {24'b0, debounced sw[15:8]}.
REQ-010 in_port2  output  32  {30'b0, debounced sw[17:16]}.
REQ-011 btn_level  output  1  debounced button level.
REQ-012 btn_rise  output  1  one-cycle pulse on a debounced button 0->1 transition.
REQ-013 sw_changed  output  1  one-cycle pulse when any debounced switch bit updates.
REQ-014 sw_event_cnt  output  8  count of switch-update events.

Function
REQ-015 Each of the 19 raw inputs SHALL pass through its own two-flop synchronizer (sync1 -> sync2).
REQ-016 Each input SHALL have an independent stable register and a CNT_W-bit counter.
REQ-017 When sync2 equals stable, the counter SHALL clear to 0.
REQ-018 When sync2 differs from stable and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-019 When sync2 differs from stable and counter == DEBOUNCE_CYCLES-1, stable SHALL load sync2 and the counter SHALL clear to 0.
REQ-020 Latency: a clean raw change SHALL appear on the output at the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new raw value; for D=4, this is the 6th edge.
REQ-021 A glitch shorter than DEBOUNCE_CYCLES consecutive sync2 samples SHALL cause no output change and no pulse.
REQ-022 The in_port outputs SHALL be driven directly from the stable registers, with upper bits constant 0.
REQ-023 btn_rise SHALL be registered and high in exactly the cycle where btn_level first reads 1; a button release SHALL produce no pulse.
REQ-024 sw_changed SHALL be registered and high for exactly one cycle following any edge at which one or more switch stable bits update.
REQ-025 sw_event_cnt SHALL increment by exactly 1 per such edge, regardless of how many bits update simultaneously.
REQ-026 sw_event_cnt SHALL wrap from 255 to 0.
REQ-027 Button updates SHALL NOT affect sw_changed or sw_event_cnt.
REQ-028 Updates on different bits in consecutive cycles SHALL each produce their own pulse and count.

Reset
REQ-029 While reset is high at a rising edge, all of the following SHALL clear to 0: synchronizers, stable registers, counters, btn_rise, sw_changed, sw_event_cnt, and all in_port bits.
REQ-030 Reset asserted mid-count SHALL discard the partial count.
REQ-031 After reset deasserts, inputs held high SHALL require the full DEBOUNCE_CYCLES+2 edges to appear, and SHALL then pulse as new updates.
REQ-032 Reset SHALL take priority over every update in the same cycle.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Scenario 1, switches all high: reset, then sw_raw=18'h3FFFF held -> at edge 6, in_port0=0xFF, in_port1=0xFF, in_port2=0x3, sw_changed high for one cycle, and sw_event_cnt=1.
REQ-034 Scenario 2, short glitch: sw_raw[0] high for 3 edges then low -> in_port0 stays 0, no sw_changed pulse, and the counter returns to 0.
REQ-035 Scenario 3, button press and release: btn_raw high held -> btn_level=1 at edge 6 with a single btn_rise cycle; btn_raw low -> btn_level=0 six edges later, with no btn_rise and sw_event_cnt unchanged.
REQ-036 Scenario 4, simultaneous change: sw_raw[3] and sw_raw[12] rise on the same edge -> in_port0=0x08 and in_port1=0x10 on the same cycle, with exactly one sw_changed pulse and sw_event_cnt incremented by 1.
REQ-037 Scenario 5, reset mid-count: reset pulsed at edge 3 of a pending change -> all outputs 0; with raw held, the update appears 6 edges after reset deasserts.
REQ-038 Scenario 6, counter wrap: 256 separated switch toggles from reset -> sw_event_cnt reads 255 after the 255th toggle and 0 after the 256th.

Source files
------------

// File: rtl/io_input_conditioner.sv
// io_input_conditioner
// Conditions 18 board switches and one push-button for a soft CPU's input
// ports. Each raw line gets a two-flop synchronizer followed by a debouncer.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive synchronized
// samples that differ from the accepted level. The module also produces a
// button rising-edge pulse, a switch-update pulse and a wrapping count of
// switch-update events.
//
// Parameter contract: 1 <= DEBOUNCE_CYCLES < 2**CNT_W. The counter compares
// against DEBOUNCE_CYCLES-1, so that value must fit in CNT_W bits.

module io_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [17:0] sw_raw,
  input  logic        btn_raw,
  output logic [31:0] in_port0,
  output logic [31:0] in_port1,
  output logic [31:0] in_port2,
  output logic        btn_level,
  output logic        btn_rise,
  output logic        sw_changed,
  output logic [7:0]  sw_event_cnt
);

  // Bits 17:0 are the switches and bit 18 is the button.
  localparam int N_IN    = 19;
  localparam int BTN_BIT = 18;

  // This is the terminal count. Reaching it while the input still differs
  // from the accepted level commits the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0] w_raw;
  logic [N_IN-1:0] r_sync1;
  logic [N_IN-1:0] r_sync2;
  logic [N_IN-1:0] w_stable;
  logic [N_IN-1:0] w_update;
  logic            w_sw_update;
  logic            w_btn_rise;

  logic            r_btn_rise;
  logic            r_sw_changed;
  logic [7:0]      r_sw_event_cnt;

  assign w_raw = {btn_raw, sw_raw};

  // Two-flop synchronizer for every raw line. It is cleared by reset so that
  // post-reset latency is the full pipeline depth.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Each input has its own accepted level and run-length counter.
  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi = gi + 1) begin : g_debounce
      logic             r_stable;
      logic [CNT_W-1:0] r_cnt;
      logic             w_differ;

      assign w_differ     = r_sync2[gi] ^ r_stable;
      // The commit fires on the sample that completes the run of differing
      // samples, so the level is updated on the same edge.
      assign w_update[gi] = w_differ && (r_cnt == CNT_LAST);
      assign w_stable[gi] = r_stable;

      // Count consecutive differing samples. Any agreeing sample or a commit
      // restarts the count.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (!w_differ || w_update[gi]) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      // Load the synchronized value once the run has been long enough.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_stable <= 1'b0;
        end else if (w_update[gi]) begin
          r_stable <= r_sync2[gi];
        end
      end
    end
  endgenerate

  // The event pulses are registered on the same edge that commits the new
  // level, so each pulse lines up with the first cycle showing that level.
  assign w_sw_update = |w_update[BTN_BIT-1:0];
  assign w_btn_rise  = w_update[BTN_BIT] & r_sync2[BTN_BIT];

  // Register the event pulses and the wrapping switch-event counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_btn_rise     <= 1'b0;
      r_sw_changed   <= 1'b0;
      r_sw_event_cnt <= 8'd0;
    end else begin
      r_btn_rise   <= w_btn_rise;
      r_sw_changed <= w_sw_update;
      // One count per commit edge, however many switches committed together.
      if (w_sw_update) begin
        r_sw_event_cnt <= r_sw_event_cnt + 8'd1;
      end
    end
  end

  assign in_port0     = {24'b0, w_stable[7:0]};
  assign in_port1     = {24'b0, w_stable[15:8]};
  assign in_port2     = {30'b0, w_stable[17:16]};
  assign btn_level    = w_stable[BTN_BIT];
  assign btn_rise     = r_btn_rise;
  assign sw_changed   = r_sw_changed;
  assign sw_event_cnt = r_sw_event_cnt;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Testbench for io_input_conditioner. Each rising edge produces one expected
// output word, computed from a window of recent raw samples, and pushes it
// into a queue. An independent monitor compares the DUT outputs against the
// queue on every falling edge.

module tb_io_input_conditioner;

  localparam int D     = 4;
  localparam int CNT_W = 8;

  logic        clock;
  logic        reset;
  logic [17:0] sw_raw;
  logic        btn_raw;
  logic [31:0] in_port0;
  logic [31:0] in_port1;
  logic [31:0] in_port2;
  logic        btn_level;
  logic        btn_rise;
  logic        sw_changed;
  logic [7:0]  sw_event_cnt;

  io_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sw_raw      (sw_raw),
    .btn_raw     (btn_raw),
    .in_port0    (in_port0),
    .in_port1    (in_port1),
    .in_port2    (in_port2),
    .btn_level   (btn_level),
    .btn_rise    (btn_rise),
    .sw_changed  (sw_changed),
    .sw_event_cnt(sw_event_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected word: {in_port0, in_port1, in_port2, btn_level, btn_rise,
  // sw_changed, sw_event_cnt}.
  typedef logic [106:0] word_t;
  word_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state. hist[0] is the newest raw sample taken at an
  // edge. The synchronized value seen at an edge is the raw sample from two
  // edges earlier, so the last D synchronized samples are hist[1..D].
  logic [18:0] hist [0:D];
  logic [18:0] m_stable;
  logic        m_rise;
  logic        m_chg;
  logic [7:0]  m_cnt;

  initial begin
    for (int i = 0; i <= D; i++) hist[i] = '0;
    m_stable = '0;
    m_rise   = 1'b0;
    m_chg    = 1'b0;
    m_cnt    = 8'd0;
  end

  // Model: a level is accepted when the last D synchronized samples all
  // disagree with the currently accepted level.
  always @(posedge clock) begin
    logic [18:0] upd;
    logic        all_diff;
    if (reset) begin
      for (int i = 0; i <= D; i++) hist[i] = '0;
      m_stable = '0;
      m_rise   = 1'b0;
      m_chg    = 1'b0;
      m_cnt    = 8'd0;
    end else begin
      upd = '0;
      for (int b = 0; b < 19; b++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= D; k++) begin
          if (hist[k][b] == m_stable[b]) all_diff = 1'b0;
        end
        upd[b] = all_diff;
      end
      m_rise   = upd[18] && !m_stable[18];
      m_chg    = |upd[17:0];
      m_cnt    = m_cnt + {7'd0, m_chg};
      m_stable = m_stable ^ upd;
      for (int i = D; i >= 1; i--) hist[i] = hist[i-1];
      hist[0] = {btn_raw, sw_raw};
    end
    exp_q.push_back({24'b0, m_stable[7:0], 24'b0, m_stable[15:8],
                     30'b0, m_stable[17:16], m_stable[18], m_rise, m_chg, m_cnt});
  end

  // Monitor: sample away from the active edge and compare with the queue.
  always @(negedge clock) begin
    word_t e;
    word_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {in_port0, in_port1, in_port2, btn_level, btn_rise, sw_changed, sw_event_cnt};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got p0=%h p1=%h p2=%h lvl=%b rise=%b chg=%b cnt=%0d, expected p0=%h p1=%h p2=%h lvl=%b rise=%b chg=%b cnt=%0d",
                 $time, a[106:75], a[74:43], a[42:11], a[10], a[9], a[8], a[7:0],
                 e[106:75], e[74:43], e[42:11], e[10], e[9], e[8], e[7:0]);
      end else if (a[9] || a[8]) begin
        $display("txn t=%0t: p0=%h p1=%h p2=%h lvl=%b rise=%b chg=%b cnt=%0d",
                 $time, a[82:75], a[50:43], a[12:11], a[10], a[9], a[8], a[7:0]);
      end
    end
  end

  // Holds the given input values for n consecutive rising edges.
  task automatic drive(input logic [17:0] s, input logic b, input logic r, input int n);
    repeat (n) begin
      @(negedge clock);
      sw_raw  = s;
      btn_raw = b;
      reset   = r;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [17:0] s;
    logic        b;
    logic        r;
    reset   = 1'b1;
    sw_raw  = '0;
    btn_raw = 1'b0;

    // All switches high after reset.
    drive('0, 1'b0, 1'b1, 2);
    drive(18'h3FFFF, 1'b0, 1'b0, 10);
    // Short glitch on bit 0, starting from reset.
    drive('0, 1'b0, 1'b1, 1);
    drive(18'h00001, 1'b0, 1'b0, 3);
    drive('0, 1'b0, 1'b0, 10);
    // Button press and release.
    drive('0, 1'b1, 1'b0, 10);
    drive('0, 1'b0, 1'b0, 10);
    // Two switches rising on the same edge.
    drive(18'h01008, 1'b0, 1'b0, 10);
    // Reset arrives partway through a pending change, with raw held.
    drive(18'h000F0, 1'b1, 1'b0, 3);
    drive(18'h000F0, 1'b1, 1'b1, 1);
    drive(18'h000F0, 1'b1, 1'b0, 10);
    // Counter wrap: 256 separated toggles of bit 5, starting from reset.
    drive('0, 1'b0, 1'b1, 1);
    for (int t = 0; t < 256; t++) begin
      drive(((t % 2) == 0) ? 18'h00020 : 18'h00000, 1'b0, 1'b0, 8);
    end
    // Random traffic, including bounces and the occasional reset.
    s = '0;
    b = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) s = s ^ 18'($urandom_range(0, 262143));
      if ($urandom_range(0, 5) == 0) b = ~b;
      r = ($urandom_range(0, 199) == 0);
      drive(s, b, r, 1);
    end
    drive(s, b, 1'b0, 10);

    // Let the monitor consume the remaining expectations.
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (exp_q.size() > 1) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, expected at most 1", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
